// File: rtl/scpad_be_row_walker.sv
// Expands one scheduler tile request into a row-major stream of per-beat DRAM descriptors.
// Optional build macro SCPAD_WALKER_ALIGN_CHECK_EN adds the align_err output and drops misaligned tiles.
module scpad_be_row_walker #(
  parameter int NUM_COLS          = 32,
  parameter int ELEM_BITS         = 16,
  parameter int SCPAD_SIZE_BYTES  = 65536,
  parameter int DRAM_ADDR_WIDTH   = 32,
  parameter int MAX_DRAM_BUS_BITS = 64,
  parameter int MAX_DIM_WIDTH     = $clog2(NUM_COLS),
  parameter int MAX_REQ_WIDTH     = $clog2(NUM_COLS / (MAX_DRAM_BUS_BITS / ELEM_BITS))
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  sched_valid,
  output logic                                  sched_ready,
  input  logic                                  sched_write,
  input  logic [$clog2(SCPAD_SIZE_BYTES)-1:0]   sched_spad_addr,
  input  logic [DRAM_ADDR_WIDTH-1:0]            sched_dram_addr,
  input  logic [MAX_DIM_WIDTH-1:0]              sched_num_rows,
  input  logic [MAX_DIM_WIDTH-1:0]              sched_num_cols,
  output logic                                  beat_valid,
  input  logic                                  beat_ready,
  output logic                                  beat_write,
  output logic [DRAM_ADDR_WIDTH-1:0]            beat_dram_addr,
  output logic [$clog2(SCPAD_SIZE_BYTES)-1:0]   beat_spad_addr,
  output logic [MAX_DIM_WIDTH-1:0]              beat_row_id,
  output logic [MAX_REQ_WIDTH-1:0]              beat_sub_id,
  output logic [MAX_REQ_WIDTH-1:0]              beat_num_request,
  output logic [MAX_DRAM_BUS_BITS/ELEM_BITS-1:0] beat_vector_mask,
  output logic                                  beat_row_last,
  output logic                                  beat_tile_last,
`ifdef SCPAD_WALKER_ALIGN_CHECK_EN
  output logic                                  align_err,
`endif
  output logic                                  busy,
  output logic                                  tile_done
);

  localparam int L          = MAX_DRAM_BUS_BITS / ELEM_BITS;
  localparam int ELEM_BYTES = ELEM_BITS / 8;
  localparam int ROW_BYTES  = NUM_COLS * ELEM_BITS / 8;
  localparam int SPAD_AW    = $clog2(SCPAD_SIZE_BYTES);
  localparam int AW         = DRAM_ADDR_WIDTH;
  localparam int DW         = MAX_DIM_WIDTH;
  localparam int RW         = MAX_REQ_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Lanes carrying data: full beats except the row tail, which holds the C - sub*L leftovers.
  function automatic logic [L-1:0] lane_mask(input logic [RW-1:0] sub,
                                             input logic [RW-1:0] last_sub,
                                             input logic [DW-1:0] cols_m1);
    int          rem;
    logic [L-1:0] m;
    m   = '0;
    rem = int'(cols_m1) + 32'sd1 - int'(sub) * L;
    for (int i = 0; i < L; i++) begin
      if (sub < last_sub) m[i] = 1'b1;
      else                m[i] = (i < rem);
    end
    return m;
  endfunction

  state_t              state_r, next_state_s;
  logic                accept_s, start_s, hs_s, misalign_s;
  logic [RW-1:0]       nb_m1_s;

  logic                write_r, write_n;
  logic [DW-1:0]       cols_m1_r, cols_m1_n, rows_m1_r, rows_m1_n;
  logic [RW-1:0]       last_sub_r, last_sub_n;
  logic [AW-1:0]       row_stride_r, row_stride_n, row_base_r, row_base_n;
  logic [AW-1:0]       dram_r, dram_n;
  logic [SPAD_AW-1:0]  spad_r, spad_n;
  logic [DW-1:0]       row_r, row_n;
  logic [RW-1:0]       sub_r, sub_n;
  logic [L-1:0]        mask_r, mask_n;
  logic                row_last_r, row_last_n, tile_last_r, tile_last_n;
  logic                valid_r, ready_r, busy_r, done_r;

`ifdef SCPAD_WALKER_ALIGN_CHECK_EN
  logic                align_err_r;
  assign misalign_s = (|(sched_spad_addr & SPAD_AW'(ROW_BYTES - 1))) ||
                      (|(sched_dram_addr & AW'(ELEM_BYTES - 1)));
  assign align_err  = align_err_r;
`else
  assign misalign_s = 1'b0;
`endif

  assign nb_m1_s = RW'(sched_num_cols >> $clog2(L));

  // Next-state and handshake decode.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    hs_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (sched_valid) begin
          accept_s = 1'b1;
          if (misalign_s) next_state_s = IDLE;
          else            next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (valid_r && beat_ready) begin
          hs_s = 1'b1;
          if (tile_last_r) next_state_s = DONE;
          else             next_state_s = RUN;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
    start_s = accept_s && !misalign_s;
  end

  // Next beat descriptor: loaded on acceptance, advanced on handshake, otherwise held.
  always_comb begin
    write_n      = write_r;
    cols_m1_n    = cols_m1_r;
    rows_m1_n    = rows_m1_r;
    last_sub_n   = last_sub_r;
    row_stride_n = row_stride_r;
    row_base_n   = row_base_r;
    dram_n       = dram_r;
    spad_n       = spad_r;
    row_n        = row_r;
    sub_n        = sub_r;
    mask_n       = mask_r;
    row_last_n   = row_last_r;
    tile_last_n  = tile_last_r;
    if (start_s) begin
      write_n      = sched_write;
      cols_m1_n    = sched_num_cols;
      rows_m1_n    = sched_num_rows;
      last_sub_n   = nb_m1_s;
      row_stride_n = (AW'(sched_num_cols) + AW'(32'd1)) * AW'(ELEM_BYTES);
      row_base_n   = sched_dram_addr;
      dram_n       = sched_dram_addr;
      spad_n       = sched_spad_addr;
      row_n        = '0;
      sub_n        = '0;
      mask_n       = lane_mask('0, nb_m1_s, sched_num_cols);
      row_last_n   = (nb_m1_s == '0);
      tile_last_n  = (nb_m1_s == '0) && (sched_num_rows == '0);
    end else if (hs_s) begin
      if (row_last_r) begin
        row_n      = row_r + DW'(1);
        sub_n      = '0;
        row_base_n = row_base_r + row_stride_r;
        dram_n     = row_base_n;
        spad_n     = spad_r + SPAD_AW'(ROW_BYTES);
      end else begin
        sub_n  = sub_r + RW'(1);
        dram_n = dram_r + AW'(L * ELEM_BYTES);
      end
      mask_n      = lane_mask(sub_n, last_sub_r, cols_m1_r);
      row_last_n  = (sub_n == last_sub_r);
      tile_last_n = row_last_n && (row_n == rows_m1_r);
    end else begin
      mask_n = mask_r;
    end
  end

  // State, descriptor and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r      <= IDLE;
      write_r      <= 1'b0;
      cols_m1_r    <= '0;
      rows_m1_r    <= '0;
      last_sub_r   <= '0;
      row_stride_r <= '0;
      row_base_r   <= '0;
      dram_r       <= '0;
      spad_r       <= '0;
      row_r        <= '0;
      sub_r        <= '0;
      mask_r       <= '0;
      row_last_r   <= 1'b0;
      tile_last_r  <= 1'b0;
      valid_r      <= 1'b0;
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
`ifdef SCPAD_WALKER_ALIGN_CHECK_EN
      align_err_r  <= 1'b0;
`endif
    end else begin
      state_r      <= next_state_s;
      write_r      <= write_n;
      cols_m1_r    <= cols_m1_n;
      rows_m1_r    <= rows_m1_n;
      last_sub_r   <= last_sub_n;
      row_stride_r <= row_stride_n;
      row_base_r   <= row_base_n;
      dram_r       <= dram_n;
      spad_r       <= spad_n;
      row_r        <= row_n;
      sub_r        <= sub_n;
      mask_r       <= mask_n;
      row_last_r   <= row_last_n;
      tile_last_r  <= tile_last_n;
      valid_r      <= (next_state_s == RUN);
      ready_r      <= (next_state_s == IDLE);
      busy_r       <= (next_state_s != IDLE);
      done_r       <= (next_state_s == DONE);
`ifdef SCPAD_WALKER_ALIGN_CHECK_EN
      align_err_r  <= accept_s && misalign_s;
`endif
    end
  end

  assign sched_ready      = ready_r;
  assign beat_valid       = valid_r;
  assign beat_write       = write_r;
  assign beat_dram_addr   = dram_r;
  assign beat_spad_addr   = spad_r;
  assign beat_row_id      = row_r;
  assign beat_sub_id      = sub_r;
  assign beat_num_request = last_sub_r;
  assign beat_vector_mask = mask_r;
  assign beat_row_last    = row_last_r;
  assign beat_tile_last   = tile_last_r;
  assign busy             = busy_r;
  assign tile_done        = done_r;

endmodule
